fft_spectrum_frame: RTL and testbench

FFT_SPECTRUM_FRAME -- requirements
Module: fft_spectrum_frame

---
 rtl/fft_spectrum_frame_pkg.sv | 18 +
 rtl/fft_spectrum_frame_log8.sv | 23 ++
 rtl/fft_spectrum_frame.sv | 212 +++++++++++++++++++++
 tb/tb_fft_spectrum_frame.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_spectrum_frame_pkg.sv
// rtl/fft_spectrum_frame_pkg.sv - shared FSM encoding and datapath constants
package fft_spectrum_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Register stages between an accepted bin and its display write
  localparam int PIPE_DEPTH = 4;
  // Bar height written to the display RAM
  localparam int HEIGHT_W   = 8;
  // Width of squared magnitude; 2*(2^15)^2 = 2^31 still fits unsigned
  localparam int SUM_W      = 32;

endpackage

// File: rtl/fft_spectrum_frame_log8.sv
// rtl/fft_spectrum_frame_log8.sv - piecewise-linear log2 compressor, 32-bit power to 8-bit height
module spec_log8
  import fft_spectrum_frame_pkg::*;
(
  input  logic [SUM_W-1:0]    sum,
  output logic [HEIGHT_W-1:0] height
);

  logic [4:0] msb;
  logic [2:0] mant;

  // Leading-one index is the exponent; the three bits under it form a linear mantissa
  always_comb begin
    msb = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (sum[i]) msb = 5'(i);
    end
    // Appending three zeros makes the mantissa zero-filled for small exponents
    mant   = 3'({sum, 3'b000} >> msb);
    height = (sum == '0) ? '0 : {msb, mant};
  end

endmodule

// File: rtl/fft_spectrum_frame.sv
// rtl/fft_spectrum_frame.sv - FFT frame capture, log magnitude and peak-hold display writer
module fft_spectrum_frame
  import fft_spectrum_frame_pkg::*;
#(
  parameter int N_BINS    = 256,
  parameter int ADDR_W    = 8,
  parameter int DECAY     = 2,
  parameter int FRAME_DIV = 4
) (
  input  logic                fft_clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic                s_sop,
  input  logic signed [15:0]  s_re,
  input  logic signed [15:0]  s_im,
  input  logic                freeze,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [HEIGHT_W-1:0] wr_data,
  output logic                frame_done,
  output logic                overrun
);

  localparam int FLUSH_W = $clog2(PIPE_DEPTH);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   bin_cnt;
  logic [1:0]          frame_cnt;
  logic                frame_wr;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic                flush_last;
  logic                clr_active;
  logic [ADDR_W-1:0]   clr_idx;

  logic                accept;
  logic                restart;
  logic                set_overrun;
  logic [ADDR_W-1:0]   cur_idx;
  logic                cur_wr;

  logic signed [31:0]  re_ext;
  logic signed [31:0]  im_ext;
  logic [SUM_W-1:0]    re_sq;
  logic [SUM_W-1:0]    im_sq;

  logic                p1_valid;
  logic [ADDR_W-1:0]   p1_addr;
  logic [SUM_W-1:0]    p1_re2;
  logic [SUM_W-1:0]    p1_im2;
  logic                p2_valid;
  logic [ADDR_W-1:0]   p2_addr;
  logic [SUM_W-1:0]    p2_sum;
  logic [HEIGHT_W-1:0] p2_height;
  logic                p3_valid;
  logic [ADDR_W-1:0]   p3_addr;
  logic [HEIGHT_W-1:0] p3_height;

  logic [HEIGHT_W-1:0] hold [N_BINS];
  logic [HEIGHT_W-1:0] hold_cur;
  logic [HEIGHT_W-1:0] hold_dec;
  logic [HEIGHT_W-1:0] new_height;

  assign flush_last = (flush_cnt == FLUSH_W'(PIPE_DEPTH - 1));

  // FSM state register
  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state, bin acceptance and restart decisions
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    restart     = 1'b0;
    set_overrun = 1'b0;
    frame_done  = 1'b0;
    cur_idx     = bin_cnt;
    cur_wr      = frame_wr;
    case (state)
      ST_IDLE: begin
        // The hold clear sweep owns the table, so no frame may start yet
        if (s_valid && s_sop && !clr_active) begin
          accept     = 1'b1;
          restart    = 1'b1;
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (s_valid) begin
          accept = 1'b1;
          if (s_sop) begin
            restart     = 1'b1;
            set_overrun = 1'b1;
          end else if (bin_cnt == ADDR_W'(N_BINS - 1)) begin
            next_state = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        frame_done = frame_wr;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    // A new frame decides at its sop whether it reaches the display
    if (restart) begin
      cur_idx = '0;
      cur_wr  = (frame_cnt == 2'd0) && !freeze;
    end
  end

  // Bin counter, frame decimation counter, flush timer and sticky overrun
  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) begin
      bin_cnt   <= '0;
      frame_cnt <= '0;
      frame_wr  <= 1'b0;
      flush_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (accept)      bin_cnt  <= cur_idx + ADDR_W'(1);
      if (restart)     frame_wr <= cur_wr;
      if (set_overrun) overrun  <= 1'b1;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FLUSH_W'(1) : '0;
      if (state == ST_DONE) begin
        frame_cnt <= (frame_cnt == 2'(FRAME_DIV - 1)) ? 2'd0 : frame_cnt + 2'd1;
      end
    end
  end

  // Post-reset sweep that walks every hold entry back to zero
  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) begin
      clr_active <= 1'b1;
      clr_idx    <= '0;
    end else if (clr_active) begin
      clr_idx <= clr_idx + ADDR_W'(1);
      if (clr_idx == ADDR_W'(N_BINS - 1)) clr_active <= 1'b0;
    end
  end

  assign re_ext = {{16{s_re[15]}}, s_re};
  assign im_ext = {{16{s_im[15]}}, s_im};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  spec_log8 u_log8 (
    .sum    (p2_sum),
    .height (p2_height)
  );

  // Squares, power sum and height stages; only bins of written frames carry valid
  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) begin
      p1_valid  <= 1'b0;
      p1_addr   <= '0;
      p1_re2    <= '0;
      p1_im2    <= '0;
      p2_valid  <= 1'b0;
      p2_addr   <= '0;
      p2_sum    <= '0;
      p3_valid  <= 1'b0;
      p3_addr   <= '0;
      p3_height <= '0;
    end else begin
      p1_valid  <= accept && cur_wr;
      p1_addr   <= cur_idx;
      p1_re2    <= re_sq;
      p1_im2    <= im_sq;
      p2_valid  <= p1_valid;
      p2_addr   <= p1_addr;
      p2_sum    <= p1_re2 + p1_im2;
      p3_valid  <= p2_valid;
      p3_addr   <= p2_addr;
      p3_height <= p2_height;
    end
  end

  // Peak hold: previous bar decays by DECAY, floored at zero, unless the new bar is taller
  always_comb begin
    hold_cur   = hold[p3_addr];
    hold_dec   = (hold_cur > HEIGHT_W'(DECAY)) ? hold_cur - HEIGHT_W'(DECAY) : '0;
    new_height = (p3_height > hold_dec) ? p3_height : hold_dec;
  end

  // Hold table update; the clear sweep has priority and frames cannot start during it
  always_ff @(posedge fft_clk) begin
    if (clr_active)    hold[clr_idx] <= '0;
    else if (p3_valid) hold[p3_addr] <= new_height;
  end

  // Display RAM write port
  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= p3_valid;
      if (p3_valid) begin
        wr_addr <= p3_addr;
        wr_data <= new_height;
      end
    end
  end

endmodule

// File: tb/tb_fft_spectrum_frame.sv
// tb/tb_fft_spectrum_frame.sv - self-checking bench for fft_spectrum_frame
module tb_fft_spectrum_frame;

  localparam int N_BINS    = 256;
  localparam int ADDR_W    = 8;
  localparam int DECAY     = 2;
  localparam int FRAME_DIV = 4;

  logic               fft_clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_sop;
  logic signed [15:0] s_re;
  logic signed [15:0] s_im;
  logic               freeze;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_data;
  logic               frame_done;
  logic               overrun;

  fft_spectrum_frame #(
    .N_BINS    (N_BINS),
    .ADDR_W    (ADDR_W),
    .DECAY     (DECAY),
    .FRAME_DIV (FRAME_DIV)
  ) dut (
    .fft_clk    (fft_clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_sop      (s_sop),
    .s_re       (s_re),
    .s_im       (s_im),
    .freeze     (freeze),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 fft_clk = ~fft_clk;

  int cyc = 0;
  always @(posedge fft_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_fd[$];
  int  exp_ovr_cyc = 1 << 30;
  int  hold_m[N_BINS];
  int  fcnt_m      = 0;
  bit  in_frame_m  = 1'b0;
  int  bin_m       = 0;
  bit  written_m   = 1'b0;
  int  sweep_end_m = 0;
  bit  chk_en      = 1'b0;

  int  wr_cnt;
  int  fd_cnt;
  int  fd_last_cyc;
  int  last_bin_cyc;
  int  addr_log[$];
  int  data_log[$];
  bit  e_en;
  bit  e_fd;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Height from power: 8 per octave plus eighths of the octave, truncated
  function automatic int height_m(input longint sum);
    int     p;
    longint m;
    if (sum == 0) return 0;
    p = 0;
    while ((longint'(1) << (p + 1)) <= sum) p++;
    m = ((sum - (longint'(1) << p)) * 8) >> p;
    return p * 8 + int'(m);
  endfunction

  function automatic void bin_data(input int mode, input int k, output int re, output int im);
    case (mode)
      0: begin re = 256; im = 0; end
      1: begin re = 0; im = 0; end
      2: begin
        re = (k == 5) ? -32768 : 0;
        im = (k == 5) ? -32768 : 0;
      end
      3: begin re = k * 131 - 16000; im = 900 - k * 7; end
      default: begin re = 1; im = 1; end
    endcase
  endfunction

  function automatic int data_at(input int i);
    return (i < data_log.size()) ? data_log[i] : -1;
  endfunction

  function automatic int addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : -1;
  endfunction

  // Frame-level model of what the display must receive for one driven cycle
  task automatic model_bin(input bit v, input bit sop, input int re, input int im, input bit frz);
    bit     acc;
    bit     rs;
    longint sum;
    int     h;
    int     dec;
    int     nv;
    wr_t    w;
    acc = 1'b0;
    rs  = 1'b0;
    if (v) begin
      if (!in_frame_m) begin
        if (sop && cyc >= sweep_end_m) begin
          acc = 1'b1;
          rs  = 1'b1;
        end
      end else begin
        acc = 1'b1;
        if (sop) begin
          rs = 1'b1;
          if (exp_ovr_cyc > cyc + 1) exp_ovr_cyc = cyc + 1;
        end
      end
    end
    if (rs) begin
      bin_m      = 0;
      written_m  = (fcnt_m == 0) && !frz;
      in_frame_m = 1'b1;
    end
    if (acc) begin
      if (written_m) begin
        sum = longint'(re) * re + longint'(im) * im;
        h   = height_m(sum);
        dec = (hold_m[bin_m] > DECAY) ? hold_m[bin_m] - DECAY : 0;
        nv  = (h > dec) ? h : dec;
        hold_m[bin_m] = nv;
        w.cyc  = cyc + 4;
        w.addr = bin_m;
        w.data = nv;
        exp_wr.push_back(w);
      end
      if (bin_m == N_BINS - 1) begin
        in_frame_m = 1'b0;
        if (written_m) exp_fd.push_back(cyc + 5);
        fcnt_m = (fcnt_m + 1) % FRAME_DIV;
      end
      bin_m = (bin_m + 1) % N_BINS;
    end
  endtask

  task automatic drive(input bit v, input bit sop, input int re, input int im, input bit frz);
    @(posedge fft_clk);
    #1;
    s_valid = v;
    s_sop   = sop;
    s_re    = 16'(re);
    s_im    = 16'(im);
    freeze  = frz;
    model_bin(v, sop, re, im, frz);
  endtask

  task automatic send_frame(input int mode, input bit frz, input bit gaps);
    int re;
    int im;
    for (int k = 0; k < N_BINS; k++) begin
      bin_data(mode, k, re, im);
      drive(1'b1, k == 0, re, im, frz);
      if (k == N_BINS - 1) last_bin_cyc = cyc;
      // Idle cycle inside the frame with an unqualified sop and junk data
      if (gaps && (k % 37) == 10) drive(1'b0, 1'b1, 1234, -77, frz);
    end
    // A bin without sop after the frame must be ignored
    drive(1'b1, 1'b0, 500, 500, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic clear_logs();
    wr_cnt = 0;
    fd_cnt = 0;
    addr_log.delete();
    data_log.delete();
  endtask

  task automatic do_reset(input bit busy);
    @(posedge fft_clk);
    #1;
    if (busy) check("wr_en_before_rst", wr_en, 1);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_sop   = 1'b0;
    exp_wr.delete();
    exp_fd.delete();
    exp_ovr_cyc = 1 << 30;
    for (int i = 0; i < N_BINS; i++) hold_m[i] = 0;
    fcnt_m     = 0;
    in_frame_m = 1'b0;
    bin_m      = 0;
    written_m  = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    repeat (3) @(posedge fft_clk);
    #1;
    rst = 1'b0;
    sweep_end_m = cyc + N_BINS;
    // A sop while the hold table is still being cleared must not start a frame
    drive(1'b1, 1'b1, 256, 0, 1'b0);
    while (cyc < sweep_end_m + 4) drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Compare DUT outputs against the model on every falling edge
  always @(negedge fft_clk) begin
    if (chk_en) begin
      e_en = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
      check("wr_en", wr_en, e_en);
      if (e_en) begin
        check("wr_addr", wr_addr, exp_wr[0].addr);
        check("wr_data", wr_data, exp_wr[0].data);
        void'(exp_wr.pop_front());
      end
      e_fd = (exp_fd.size() > 0) && (exp_fd[0] == cyc);
      check("frame_done", frame_done, e_fd);
      if (e_fd) void'(exp_fd.pop_front());
      check("overrun", overrun, (cyc >= exp_ovr_cyc) ? 1 : 0);
      if (wr_en) begin
        wr_cnt++;
        addr_log.push_back(int'(wr_addr));
        data_log.push_back(int'(wr_data));
      end
      if (frame_done) begin
        fd_cnt++;
        fd_last_cyc = cyc;
      end
    end
  end

  initial begin
    int re;
    int im;
    int bad;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_re    = '0;
    s_im    = '0;
    freeze  = 1'b0;
    clear_logs();
    repeat (2) @(posedge fft_clk);
    chk_en = 1'b1;
    do_reset(1'b0);

    // Frame 0: all bins 256+0j -> 256 sequential writes of 128
    clear_logs();
    send_frame(0, 1'b0, 1'b1);
    check("f0_write_count", wr_cnt, 256);
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) begin
      if (addr_log[i] != i || data_log[i] != 128) bad++;
    end
    check("f0_addr_seq_data128", bad, 0);
    check("f0_done_count", fd_cnt, 1);
    check("f0_done_latency", fd_last_cyc - last_bin_cyc, 5);

    // Frames 1..3 are decimated away
    clear_logs();
    send_frame(3, 1'b0, 1'b1);
    send_frame(3, 1'b1, 1'b0);
    send_frame(3, 1'b0, 1'b0);
    check("f1_3_write_count", wr_cnt, 0);
    check("f1_3_done_count", fd_cnt, 0);

    // Frame 4: zero input, hold decays 128 -> 126
    clear_logs();
    send_frame(1, 1'b0, 1'b0);
    check("f4_write_count", wr_cnt, 256);
    check("f4_first_126", data_at(0), 126);
    check("f4_last_126", data_at(255), 126);
    check("f4_done_count", fd_cnt, 1);

    clear_logs();
    repeat (3) send_frame(1, 1'b0, 1'b0);
    check("f5_7_write_count", wr_cnt, 0);
    check("f5_7_done_count", fd_cnt, 0);

    // Frame 8 would be written but freeze suppresses it
    clear_logs();
    send_frame(0, 1'b1, 1'b0);
    check("f8_frozen_writes", wr_cnt, 0);
    check("f8_frozen_done", fd_cnt, 0);
    repeat (3) send_frame(1, 1'b0, 1'b0);

    // Frame 12: height 8 loses to decayed hold 124
    clear_logs();
    send_frame(4, 1'b0, 1'b0);
    check("f12_decay_124", data_at(0), 124);
    check("f12_decay_124_hi", data_at(200), 124);
    repeat (3) send_frame(3, 1'b0, 1'b0);

    // Frame 16: premature sop at bin 100 restarts the frame
    clear_logs();
    for (int k = 0; k < 100; k++) begin
      bin_data(3, k, re, im);
      drive(1'b1, k == 0, re, im, 1'b0);
    end
    for (int k = 0; k < 120; k++) begin
      bin_data(3, k, re, im);
      drive(1'b1, k == 0, re, im, 1'b0);
    end
    check("ovr_held", overrun, 1);
    do_reset(1'b1);
    check("ovr_addr_99", addr_at(99), 99);
    check("ovr_restart_addr0", addr_at(100), 0);
    check("ovr_restart_addr1", addr_at(101), 1);

    // After reset the hold table is zero: bin 5 at full scale, others zero
    clear_logs();
    send_frame(2, 1'b0, 1'b0);
    check("b0_addr5", addr_at(5), 5);
    check("b0_data5_248", data_at(5), 248);
    check("b0_data0_zero", data_at(0), 0);
    check("b0_data6_zero", data_at(6), 0);
    repeat (3) send_frame(1, 1'b0, 1'b0);
    clear_logs();
    send_frame(1, 1'b0, 1'b1);
    check("b4_data5_246", data_at(5), 246);
    check("b4_data6_sat0", data_at(6), 0);
    check("b4_done_count", fd_cnt, 1);
    check("model_drained", exp_wr.size() + exp_fd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
